// File: rtl/obi_ram_arbiter.sv
`default_nettype none
// =============================================================================
// obi_ram_arbiter : one single-port memory shared by an OBI fetch and data port.
// Revision: 1.0
// =============================================================================
module obi_ram_arbiter #(
  parameter int ADDR_WIDTH  = 22,
  parameter int RAM_LATENCY = 1,
  parameter int MAX_STALL   = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,

  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,

  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,

  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  localparam logic [3:0] STALL_LIMIT = 4'(MAX_STALL);

  logic [3:0] stall_cnt_q;
  logic [3:0] stall_cnt_d;
  logic       fetch_forced;
  logic       instr_gnt;
  logic       data_gnt;

  // ---------------------------------------------------------------------------
  // Arbitration: data has priority until fetch has lost MAX_STALL times in a row.
  // Grants are held low during reset so nothing reaches the memory then.
  // ---------------------------------------------------------------------------
  assign fetch_forced = (stall_cnt_q == STALL_LIMIT);
  assign instr_gnt    = ~rst_i & instr_req_i & (~data_req_i | fetch_forced);
  assign data_gnt     = ~rst_i & data_req_i & ~instr_gnt;

  assign instr_gnt_o  = instr_gnt;
  assign data_gnt_o   = data_gnt;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!instr_req_i || instr_gnt) begin
      stall_cnt_d = 4'd0;
    end else if (stall_cnt_q < STALL_LIMIT) begin
      stall_cnt_d = stall_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= 4'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory drive
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_en_o    = 1'b0;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_wdata_o = 32'h0;
    if (instr_gnt) begin
      ram_en_o   = 1'b1;
      ram_addr_o = instr_addr_i;
      ram_be_o   = 4'hF;
    end else if (data_gnt) begin
      ram_en_o    = 1'b1;
      ram_addr_o  = data_addr_i;
      ram_we_o    = data_we_i;
      ram_be_o    = data_be_i;
      ram_wdata_o = data_wdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Response pipeline: one {valid, owner} stage per cycle of memory latency.
  // owner = 1 marks a data-port transaction.
  // ---------------------------------------------------------------------------
  logic [RAM_LATENCY-1:0] pipe_valid_q;
  logic [RAM_LATENCY-1:0] pipe_owner_q;

  generate
    if (RAM_LATENCY > 1) begin : g_deep_pipe
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          pipe_valid_q <= '0;
          pipe_owner_q <= '0;
        end else begin
          pipe_valid_q <= {pipe_valid_q[RAM_LATENCY-2:0], ram_en_o};
          pipe_owner_q <= {pipe_owner_q[RAM_LATENCY-2:0], data_gnt};
        end
      end
    end else begin : g_single_pipe
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          pipe_valid_q <= '0;
          pipe_owner_q <= '0;
        end else begin
          pipe_valid_q <= ram_en_o;
          pipe_owner_q <= data_gnt;
        end
      end
    end
  endgenerate

  assign instr_rvalid_o = pipe_valid_q[RAM_LATENCY-1] & ~pipe_owner_q[RAM_LATENCY-1];
  assign data_rvalid_o  = pipe_valid_q[RAM_LATENCY-1] &  pipe_owner_q[RAM_LATENCY-1];

  assign instr_rdata_o  = instr_rvalid_o ? ram_rdata_i : 32'h0;
  assign data_rdata_o   = data_rvalid_o  ? ram_rdata_i : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_obi_ram_arbiter.sv
`default_nettype none
// =============================================================================
// tb_obi_ram_arbiter : scoreboard bench, three latency configurations in lockstep.
// Revision: 1.0
// =============================================================================
module tb_obi_ram_arbiter;

  localparam int AW        = 22;
  localparam int NCFG      = 3;
  localparam int MAX_STALL = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b0;
  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic          data_req;
  logic [AW-1:0] data_addr;
  logic          data_we;
  logic [3:0]    data_be;
  logic [31:0]   data_wdata;

  logic          instr_gnt    [NCFG];
  logic          instr_rvalid [NCFG];
  logic [31:0]   instr_rdata  [NCFG];
  logic          data_gnt     [NCFG];
  logic          data_rvalid  [NCFG];
  logic [31:0]   data_rdata   [NCFG];
  logic          ram_en       [NCFG];
  logic [AW-1:0] ram_addr     [NCFG];
  logic          ram_we       [NCFG];
  logic [3:0]    ram_be       [NCFG];
  logic [31:0]   ram_wdata    [NCFG];
  logic [31:0]   ram_rdata    [NCFG];

  typedef struct {
    bit          is_data;
    bit          is_read;
    int          cyc;
    logic [31:0] data;
  } exp_t;

  exp_t        hist[$];
  int          rd_ptr [NCFG];
  int          cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [31:0] mmem [64];
  int          model_stall;

  bit          ip, dp, dwe;
  logic [AW-1:0] ia, da;
  logic [3:0]  dbe;
  logic [31:0] dwd;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0:       return 32'h11111111;
      1:       return 32'h22222222;
      2:       return 32'h33333333;
      default: return 32'(i) * 32'h9E3779B1;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Each configuration has its own memory model and response monitor.
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int LAT = g + 1;
    logic [31:0] dmem    [64];
    logic [31:0] rd_pipe [4];

    obi_ram_arbiter #(
      .ADDR_WIDTH (AW),
      .RAM_LATENCY(LAT),
      .MAX_STALL  (MAX_STALL)
    ) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .instr_req_i   (instr_req),
      .instr_addr_i  (instr_addr),
      .instr_gnt_o   (instr_gnt[g]),
      .instr_rvalid_o(instr_rvalid[g]),
      .instr_rdata_o (instr_rdata[g]),
      .data_req_i    (data_req),
      .data_addr_i   (data_addr),
      .data_we_i     (data_we),
      .data_be_i     (data_be),
      .data_wdata_i  (data_wdata),
      .data_gnt_o    (data_gnt[g]),
      .data_rvalid_o (data_rvalid[g]),
      .data_rdata_o  (data_rdata[g]),
      .ram_en_o      (ram_en[g]),
      .ram_addr_o    (ram_addr[g]),
      .ram_we_o      (ram_we[g]),
      .ram_be_o      (ram_be[g]),
      .ram_wdata_o   (ram_wdata[g]),
      .ram_rdata_i   (ram_rdata[g])
    );

    initial begin
      for (int i = 0; i < 64; i++) dmem[i] = init_word(i);
      for (int k = 0; k < 4; k++) rd_pipe[k] = 32'hBAD0BAD0;
    end

    always @(posedge clk) begin
      for (int k = 3; k > 0; k--) rd_pipe[k] <= rd_pipe[k-1];
      rd_pipe[0] <= 32'hBAD0BAD0;
      if (ram_en[g]) begin
        if (ram_we[g]) begin
          for (int b = 0; b < 4; b++)
            if (ram_be[g][b]) dmem[ram_addr[g][7:2]][8*b +: 8] = ram_wdata[g][8*b +: 8];
        end else begin
          rd_pipe[0] <= dmem[ram_addr[g][7:2]];
        end
      end
    end

    assign ram_rdata[g] = rd_pipe[LAT-1];

    always @(negedge clk) begin : b_mon
      exp_t e;
      chk($sformatf("both_rvalid[%0d]", g), 64'(instr_rvalid[g] & data_rvalid[g]), 64'd0);
      chk($sformatf("irdata_idle[%0d]", g), 64'(instr_rvalid[g] ? 32'h0 : instr_rdata[g]), 64'd0);
      chk($sformatf("drdata_idle[%0d]", g), 64'(data_rvalid[g] ? 32'h0 : data_rdata[g]), 64'd0);
      if (instr_rvalid[g] || data_rvalid[g]) begin
        if (rd_ptr[g] >= hist.size()) begin
          chk($sformatf("unexpected_rvalid[%0d]", g), 64'd1, 64'd0);
        end else begin
          e = hist[rd_ptr[g]];
          rd_ptr[g]++;
          chk($sformatf("rvalid_port[%0d]", g), 64'({instr_rvalid[g], data_rvalid[g]}),
              e.is_data ? 64'd1 : 64'd2);
          chk($sformatf("rvalid_cycle[%0d]", g), 64'(cyc), 64'(e.cyc + LAT));
          if (e.is_read)
            chk($sformatf("rdata[%0d]", g), 64'(e.is_data ? data_rdata[g] : instr_rdata[g]),
                64'(e.data));
        end
      end else if (rd_ptr[g] < hist.size() && hist[rd_ptr[g]].cyc + LAT <= cyc) begin
        chk($sformatf("missing_rvalid[%0d]", g), 64'd0, 64'd1);
        rd_ptr[g]++;
      end
    end
  end

  // Reference: grant and memory drive from the arbitration rules, responses
  // recorded in grant order with the data they must return.
  task automatic drive_and_check();
    bit          eig, edg;
    logic [63:0] exp_drive;
    instr_req  = ip;
    instr_addr = ia;
    data_req   = dp;
    data_addr  = da;
    data_we    = dwe;
    data_be    = dbe;
    data_wdata = dwd;
    #1;
    eig = ip && (!dp || model_stall == MAX_STALL);
    edg = dp && !eig;
    if (eig)      exp_drive = {2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, ia, 32'h0};
    else if (edg) exp_drive = {2'b00, 1'b0, 1'b1, 1'b1, dwe, dbe, da, dwd};
    else          exp_drive = 64'd0;
    for (int g = 0; g < NCFG; g++)
      chk($sformatf("ram_drive[%0d]", g),
          {2'b00, instr_gnt[g], data_gnt[g], ram_en[g], ram_we[g], ram_be[g], ram_addr[g], ram_wdata[g]},
          exp_drive);
    if (!ip || eig)                  model_stall = 0;
    else if (model_stall < MAX_STALL) model_stall++;
    if (eig) begin
      hist.push_back('{is_data: 1'b0, is_read: 1'b1, cyc: cyc, data: mmem[ia[7:2]]});
      ip = 1'b0;
    end
    if (edg) begin
      if (dwe) begin
        for (int b = 0; b < 4; b++)
          if (dbe[b]) mmem[da[7:2]][8*b +: 8] = dwd[8*b +: 8];
        hist.push_back('{is_data: 1'b1, is_read: 1'b0, cyc: cyc, data: 32'h0});
      end else begin
        hist.push_back('{is_data: 1'b1, is_read: 1'b1, cyc: cyc, data: mmem[da[7:2]]});
      end
      dp = 1'b0;
    end
  endtask

  // New requests are only taken when the port has nothing pending.
  task automatic step(input bit ni, input logic [AW-1:0] ai, input bit nd,
                      input logic [AW-1:0] ad, input bit we, input logic [3:0] be,
                      input logic [31:0] wd);
    @(posedge clk);
    #1;
    if (ni && !ip) begin ip = 1'b1; ia = ai; end
    if (nd && !dp) begin dp = 1'b1; da = ad; dwe = we; dbe = be; dwd = wd; end
    drive_and_check();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, '0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic check_zero();
    for (int g = 0; g < NCFG; g++) begin
      chk($sformatf("reset_ctrl[%0d]", g),
          {instr_gnt[g], data_gnt[g], instr_rvalid[g], data_rvalid[g], ram_en[g], ram_we[g],
           ram_be[g], ram_addr[g], ram_wdata[g]}, 64'd0);
      chk($sformatf("reset_rdata[%0d]", g), {instr_rdata[g], data_rdata[g]}, 64'd0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_req = 1'b0; instr_addr = '0; data_req = 1'b0; data_addr = '0;
    data_we = 1'b0; data_be = 4'h0; data_wdata = 32'h0;
    ip = 1'b0; dp = 1'b0; dwe = 1'b0; ia = '0; da = '0; dbe = 4'h0; dwd = 32'h0;
    model_stall = 0;
    for (int i = 0; i < 64; i++) mmem[i] = init_word(i);
    for (int g = 0; g < NCFG; g++) rd_ptr[g] = 0;

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_zero();
    @(posedge clk);
    #1 rst = 1'b0;

    // Fetch only, preloaded words at 0x0/0x4/0x8
    step(1'b1, 22'h0, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    step(1'b1, 22'h4, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    step(1'b1, 22'h8, 1'b0, '0, 1'b0, 4'h0, 32'h0);
    idle(4);

    // Partial write then read back
    step(1'b0, '0, 1'b1, 22'h10, 1'b1, 4'b0011, 32'hDEADBEEF);
    step(1'b0, '0, 1'b1, 22'h10, 1'b0, 4'hF, 32'h0);
    idle(4);

    // Continuous contention: data x4 then forced fetch, repeating
    for (int k = 0; k < 15; k++) begin
      step(1'b1, AW'($urandom()), 1'b1, AW'($urandom()), 1'b0, 4'hF, 32'h0);
      chk($sformatf("contention_pattern_%0d", k), 64'(instr_gnt[0]), 64'(k % 5 == 4));
    end
    idle(4);

    // Alternating single-port requests
    for (int k = 0; k < 12; k++)
      step(k % 2 == 0, AW'($urandom()), k % 2 == 1, AW'($urandom()),
           1'($urandom()), 4'($urandom()), $urandom());

    // Idle stretch
    idle(10);

    // Reset one cycle after a data grant: that response must never appear
    step(1'b0, '0, 1'b1, 22'h20, 1'b0, 4'hF, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    instr_req = 1'b0; data_req = 1'b0;
    ip = 1'b0; dp = 1'b0; model_stall = 0;
    for (int g = 0; g < NCFG; g++) rd_ptr[g] = hist.size();
    #1 check_zero();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(6);

    // Randomized traffic
    for (int k = 0; k < 500; k++)
      step($urandom_range(0, 9) < 6, AW'($urandom()), $urandom_range(0, 9) < 6, AW'($urandom()),
           1'($urandom()), 4'($urandom()), $urandom());

    idle(8);
    @(negedge clk);
    #1;
    for (int g = 0; g < NCFG; g++)
      chk($sformatf("drained[%0d]", g), 64'(rd_ptr[g]), 64'(hist.size()));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
